// File: rtl/shift_sequencer.sv
// Multi-pass sequencer for the single-step MIC-1 shifter (SLL8 / SRA1).
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN: leave RUN once further passes cannot change the result.
module shift_sequencer #(
    parameter int CNT_W    = 5,
    parameter int SLL8_MAX = 4,
    parameter int SRA1_MAX = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      dout,
    output logic [31:0]      sh_in,
    output logic [1:0]       sh_set,
    input  logic [31:0]      sh_out
);

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL8 = 2'b01;
    localparam logic [1:0] OP_SRA1 = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_cnt;
    logic             err_q;
    logic             early;
    logic             last_pass;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eff_cnt = '0;
        case (op)
            OP_SLL8: eff_cnt = (count > CNT_W'(SLL8_MAX)) ? CNT_W'(SLL8_MAX) : count;
            OP_SRA1: eff_cnt = (count > CNT_W'(SRA1_MAX)) ? CNT_W'(SRA1_MAX) : count;
            default: eff_cnt = '0;
        endcase
    end

    always_comb begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        early = ((op_q == OP_SLL8) && (sh_out == 32'h0000_0000)) ||
                ((op_q == OP_SRA1) && ((sh_out == 32'h0000_0000) || (sh_out == 32'hFFFF_FFFF)));
`else
        early = 1'b0;
`endif
        // cnt is loaded non-zero on entry to RUN, so exiting at 1 keeps it from wrapping
        last_pass = (cnt == CNT_W'(1)) || early;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (eff_cnt != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (last_pass) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc   <= '0;
            op_q  <= OP_PASS;
            cnt   <= '0;
            dout  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= din;
                        op_q  <= op;
                        cnt   <= eff_cnt;
                        err_q <= (op == OP_ILL);
                        if (eff_cnt == '0) dout <= din;
                    end
                end
                ST_RUN: begin
                    acc <= sh_out;
                    cnt <= cnt - CNT_W'(1);
                    if (last_pass) dout <= sh_out;
                end
                ST_DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Illegal ops bypass RUN, so op_q reaching the shifter is always 01 or 10
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign err    = err_q;
    assign sh_in  = (state == ST_RUN) ? acc : 32'h0000_0000;
    assign sh_set = (state == ST_RUN) ? op_q : 2'b00;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural MIC-1 shifter on sh_in/sh_set/sh_out.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  count;
    logic [31:0] din;
    logic        busy, done, err;
    logic [31:0] dout, sh_in, sh_out;
    logic [1:0]  sh_set;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .count   (count),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .dout    (dout),
        .sh_in   (sh_in),
        .sh_set  (sh_set),
        .sh_out  (sh_out)
    );

    // External shifter: one step per pass
    always_comb begin
        case (sh_set)
            2'b00:   sh_out = sh_in;
            2'b01:   sh_out = {sh_in[23:0], 8'h00};
            2'b10:   sh_out = {sh_in[31], sh_in[31:1]};
            default: sh_out = 32'hDEAD_DEAD;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  count;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        logic bad_set;
        logic bad_run;
        start = 1'b1; op = v.op; count = v.count; din = v.din;
        step();
        start = 1'b0; op = 2'b00; count = '0; din = 32'h0;
        lat = 1; bad_set = 1'b0; bad_run = 1'b0;
        while (!done && lat < 60) begin
            if (sh_set == 2'b11) bad_set = 1'b1;
            if (!busy || sh_set != v.op) bad_run = 1'b1;
            step();
            lat++;
        end
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d dout", idx), dout, v.exp_dout);
        check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d run sh_set", idx), 32'({bad_set, bad_run}), 32'd0);
        check($sformatf("v%0d done busy/sh_set", idx), 32'({busy, sh_set}), 32'b100);
        step();
        check($sformatf("v%0d after done/busy/err", idx), 32'({done, busy, err}), 32'd0);
        check($sformatf("v%0d dout held", idx), dout, v.exp_dout);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 5'd7,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 1};
        vecs[1]  = '{2'b01, 5'd1,  32'hAAAA_AAAA, 32'hAAAA_AA00, 1'b0, 2};
        vecs[2]  = '{2'b10, 5'd1,  32'hAAAA_AAAA, 32'hD555_5555, 1'b0, 2};
        vecs[3]  = '{2'b10, 5'd3,  32'hAAAA_AAAA, 32'hF555_5555, 1'b0, 4};
        vecs[4]  = '{2'b01, 5'd31, 32'h1234_5678, 32'h0000_0000, 1'b0, 5};
        vecs[5]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32};
        vecs[6]  = '{2'b11, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[7]  = '{2'b01, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1};
        vecs[8]  = '{2'b01, 5'd2,  32'h1234_5678, 32'h5678_0000, 1'b0, 3};
        vecs[9]  = '{2'b10, 5'd4,  32'h7FFF_FFFF, 32'h07FF_FFFF, 1'b0, 5};
        vecs[10] = '{2'b10, 5'd31, 32'h4000_0000, 32'h0000_0000, 1'b0, 32};

        reset_n = 1'b0; start = 1'b0; op = 2'b00; count = '0; din = 32'h0;
        step();
        step();
        check("reset state", {26'd0, busy, done, err, sh_set, 1'b0}, 32'd0);
        check("reset dout", dout, 32'h0);
        check("reset sh_in", sh_in, 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // START held high through RUN must not queue a second request
        begin
            int lat;
            int n_done;
            start = 1'b1; op = 2'b01; count = 5'd3; din = 32'h1122_3344;
            step();
            op = 2'b10; count = 5'd9; din = 32'hFFFF_0000;
            lat = 1;
            while (!done && lat < 60) begin
                step();
                lat++;
            end
            start = 1'b0;
            check("busy start latency", 32'(lat), 32'd4);
            check("busy start dout", dout, 32'h4400_0000);
            n_done = 0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (done) n_done++;
            end
            check("busy start extra dones", 32'(n_done), 32'd0);
            check("busy start dout held", dout, 32'h4400_0000);
        end

        // Reset during RUN aborts without a DONE pulse
        begin
            int n_done;
            start = 1'b1; op = 2'b10; count = 5'd20; din = 32'hAAAA_AAAA;
            step();
            start = 1'b0;
            step(); step(); step();
            check("pre-reset busy", 32'(busy), 32'd1);
            reset_n = 1'b0;
            step();
            check("abort busy/done/err", {29'd0, busy, done, err}, 32'd0);
            check("abort dout", dout, 32'h0);
            check("abort sh_set", 32'(sh_set), 32'd0);
            reset_n = 1'b1;
            n_done = 0;
            for (int k = 0; k < 30; k++) begin
                step();
                if (done || busy) n_done++;
            end
            check("abort no done", 32'(n_done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
